// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the parametrised AHB-Lite to APB3 bridge.
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP,
      ST_ERR1,
      ST_ERR2
   } state_e;

   localparam logic [1:0]  OKAY              = 2'b00;
   localparam logic [1:0]  ERROR             = 2'b01;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

endpackage

// File: rtl/ahb_apb_addr_decode.sv
// Combinational APB window decoder: turns an AHB address into a hit flag,
// the slave index and a one-hot slave select.
module ahb_apb_addr_decode
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int SLV_LSB = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
   localparam int IDX_W  = $clog2(NUM_SLV)
) (
   input  logic [ADDR_W-1:0]  haddr,
   output logic               hit,
   output logic [IDX_W-1:0]   idx,
   output logic [NUM_SLV-1:0] sel
);

   localparam int TOP_LSB = SLV_LSB + IDX_W;
   localparam logic [IDX_W:0] NUM_SLV_W = (IDX_W + 1)'(NUM_SLV);

   // Offset bits inside a window never affect which slave is chosen.
   logic unused_offset;
   assign unused_offset = ^haddr[SLV_LSB-1:0];

   // A hit needs the region bits to match the base and the index to name a real slave.
   always_comb begin
      idx = haddr[SLV_LSB +: IDX_W];
      hit = (haddr[ADDR_W-1:TOP_LSB] == BASE_ADDR[ADDR_W-1:TOP_LSB]) &&
            ({1'b0, idx} < NUM_SLV_W);
      sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (hit && (idx == i[IDX_W-1:0])) sel[i] = 1'b1;
      end
   end

endmodule

// File: rtl/ahb_apb_bridge_mp.sv
// AHB-Lite slave to APB3 master bridge with NUM_SLV decoded windows, APB wait
// states and a two-cycle AHB ERROR for slave errors and unmapped addresses.
// Optional build macro AHB_APB_PSTRB_EN adds an APB4 pstrb byte-strobe output.
module ahb_apb_bridge_mp
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int SLV_LSB = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR)
) (
   input  logic               hclk,
   input  logic               hreset,
   input  logic               hsel,
   input  logic [ADDR_W-1:0]  haddr,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [DATA_W-1:0]  hwdata,
   input  logic               hreadyin,
   output logic               hreadyout,
   output logic [1:0]         hresp,
   output logic [DATA_W-1:0]  hrdata,
   output logic [NUM_SLV-1:0] psel,
   output logic               penable,
   output logic               pwrite,
   output logic [ADDR_W-1:0]  paddr,
   output logic [DATA_W-1:0]  pwdata,
   input  logic [DATA_W-1:0]  prdata,
   input  logic               pready,
   input  logic               pslverr
`ifdef AHB_APB_PSTRB_EN
   ,
   output logic [DATA_W/8-1:0] pstrb
`endif
);

   localparam int IDX_W = $clog2(NUM_SLV);

   state_e             state, state_nxt;
   logic               dec_hit;
   logic [IDX_W-1:0]   dec_idx;
   logic [NUM_SLV-1:0] dec_sel;
   logic [IDX_W-1:0]   idx_q;
   logic [NUM_SLV-1:0] idx_sel;
   logic               accept;
   logic               unused_inputs;

   ahb_apb_addr_decode #(
      .ADDR_W    (ADDR_W),
      .NUM_SLV   (NUM_SLV),
      .SLV_LSB   (SLV_LSB),
      .BASE_ADDR (BASE_ADDR)
   ) u_decode (
      .haddr (haddr),
      .hit   (dec_hit),
      .idx   (dec_idx),
      .sel   (dec_sel)
   );

`ifdef AHB_APB_PSTRB_EN
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   logic [NB-1:0] strb_calc;

   // Byte lanes covered by a transfer of 2^hsize bytes starting at the address offset.
   always_comb begin
      strb_calc = '0;
      for (int i = 0; i < NB; i++) begin
         if ((i >= int'(haddr[OFF_W-1:0])) &&
             (i < int'(haddr[OFF_W-1:0]) + (1 << hsize))) strb_calc[i] = 1'b1;
      end
   end

   assign unused_inputs = htrans[0];
`else
   assign unused_inputs = ^{htrans[0], hsize};
`endif

   // One-hot select for a write whose index was captured one cycle before SETUP.
   always_comb begin
      idx_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == i[IDX_W-1:0]) idx_sel[i] = 1'b1;
      end
   end

   // Next-state logic; new transfers are only taken when the AHB data phase is free.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE, ST_RESP, ST_ERR2: begin
            accept = hsel & hreadyin & htrans[1];
            if (accept) begin
               if (!dec_hit)    state_nxt = ST_ERR1;
               else if (hwrite) state_nxt = ST_WDATA;
               else             state_nxt = ST_SETUP;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WDATA:  state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (pready) state_nxt = pslverr ? ST_ERR1 : ST_RESP;
         end
         ST_ERR1:   state_nxt = ST_ERR2;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered AHB/APB outputs derived from the next state.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state     <= ST_IDLE;
         hreadyout <= 1'b1;
         hresp     <= OKAY;
         hrdata    <= '0;
         psel      <= '0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         idx_q     <= '0;
`ifdef AHB_APB_PSTRB_EN
         pstrb     <= '0;
`endif
      end else begin
         state     <= state_nxt;
         hreadyout <= !(state_nxt inside {ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR1});
         hresp     <= (state_nxt inside {ST_ERR1, ST_ERR2}) ? ERROR : OKAY;
         penable   <= (state_nxt == ST_ACCESS);
         if (accept && dec_hit) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            idx_q  <= dec_idx;
`ifdef AHB_APB_PSTRB_EN
            pstrb  <= hwrite ? strb_calc : '0;
`endif
         end
         if (state == ST_WDATA) pwdata <= hwdata;
         if ((state == ST_ACCESS) && pready && !pwrite) hrdata <= prdata;
         case (state_nxt)
            ST_SETUP:  psel <= (state == ST_WDATA) ? idx_sel : dec_sel;
            ST_ACCESS: psel <= psel;
            default:   psel <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Scoreboard testbench for ahb_apb_bridge_mp: directed transfers push expected
// AHB and APB results into queues, independent monitors pop and compare them.
module tb_ahb_apb_bridge_mp;

   logic        hclk, hreset;
   logic        hsel, hwrite, hreadyout;
   logic [31:0] haddr, hwdata, hrdata, paddr, pwdata, prdata;
   logic [1:0]  htrans, hresp;
   logic [2:0]  hsize;
   logic [3:0]  psel;
   logic        penable, pwrite, pready, pslverr;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          low;
   } ahb_exp_t;

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          waits;
      logic        err;
      logic [31:0] rdata;
   } apb_exp_t;

   ahb_exp_t ahb_q[$];
   apb_exp_t apb_q[$];

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_hrdata   = 32'h0;

   ahb_apb_bridge_mp dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hreadyin  (hreadyout),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue the expected results, then present one address phase until it is accepted.
   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic [3:0] exp_sel, input int waits, input logic err,
                                input logic [31:0] rdat, input logic [1:0] exp_resp,
                                input int exp_low);
      apb_exp_t a;
      ahb_exp_t h;
      bit       taken = 0;
      if (exp_sel != 4'b0000) begin
         a.sel = exp_sel; a.addr = addr; a.wr = wr; a.wdata = wdata;
         a.waits = waits; a.err = err; a.rdata = rdat;
         apb_q.push_back(a);
         if (!wr) exp_hrdata = rdat;
      end
      h.resp = exp_resp; h.rdata = exp_hrdata; h.low = exp_low;
      ahb_q.push_back(h);
      hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
      for (int i = 0; i < 60; i++) begin
         @(negedge hclk);
         if (hreadyout) begin
            taken = 1;
            break;
         end
      end
      if (!taken) checkOutput("accept_timeout", 64'd0, 64'd1);
      @(posedge hclk);
      #1;
      hsel = 1'b0; htrans = 2'b00;
      if (wr) hwdata = wdata;
   endtask

   // APB slave model: inserts the queued number of wait states for the access in progress.
   apb_exp_t cur;
   int       acc_cnt = 0;
   always @(posedge hclk) begin
      #1;
      if ((psel != 4'b0000) && penable) begin
         if (apb_q.size() > 0) begin
            cur = apb_q[0];
            if (acc_cnt < cur.waits) begin
               pready = 1'b0;
               acc_cnt++;
            end else begin
               pready = 1'b1;
            end
            prdata  = cur.rdata;
            pslverr = cur.err;
         end else begin
            pready = 1'b1;
         end
      end else begin
         pready  = 1'b0;
         pslverr = 1'b0;
         acc_cnt = 0;
      end
   end

   // APB monitor: every completed access must match the next queued APB expectation.
   apb_exp_t ma;
   always @(negedge hclk) begin
      if (!hreset && (psel != 4'b0000) && penable && pready) begin
         if (apb_q.size() == 0) begin
            checkOutput("apb_unexpected", {32'd0, paddr}, 64'd0);
         end else begin
            ma = apb_q.pop_front();
            checkOutput("apb_psel", psel, ma.sel);
            checkOutput("apb_paddr", paddr, ma.addr);
            checkOutput("apb_pwrite", pwrite, ma.wr);
            if (ma.wr) checkOutput("apb_pwdata", pwdata, ma.wdata);
         end
      end
   end

   // AHB monitor: follows each accepted data phase to its hreadyout=1 completion.
   ahb_exp_t   me;
   bit         pending = 0;
   int         low_cnt = 0;
   logic [1:0] prev_resp;
   always @(negedge hclk) begin
      if (hreset) begin
         pending = 0;
      end else begin
         if (pending) begin
            if (hreadyout) begin
               pending = 0;
               if (ahb_q.size() == 0) begin
                  checkOutput("ahb_unexpected", 64'd1, 64'd0);
               end else begin
                  me = ahb_q.pop_front();
                  checkOutput("ahb_hresp", hresp, me.resp);
                  checkOutput("ahb_hrdata", hrdata, me.rdata);
                  checkOutput("ahb_low_cycles", low_cnt, me.low);
                  if (me.resp == 2'b01) checkOutput("ahb_err_first", prev_resp, 2'b01);
               end
            end else begin
               low_cnt++;
               prev_resp = hresp;
            end
         end
         if (hsel && hreadyout && htrans[1]) begin
            pending   = 1;
            low_cnt   = 0;
            prev_resp = hresp;
         end
      end
   end

   initial begin
      bit seen;
      hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
      haddr = 32'h0; hwdata = 32'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      repeat (2) @(posedge hclk);
      #1;
      checkOutput("rst_hreadyout", hreadyout, 1'b1);
      checkOutput("rst_hresp", hresp, 2'b00);
      checkOutput("rst_hrdata", hrdata, 32'h0);
      checkOutput("rst_psel", psel, 4'b0000);
      checkOutput("rst_penable", penable, 1'b0);
      checkOutput("rst_pwrite", pwrite, 1'b0);
      checkOutput("rst_paddr", paddr, 32'h0);
      checkOutput("rst_pwdata", pwdata, 32'h0);
      @(posedge hclk);
      #2 hreset = 1'b0;
      @(posedge hclk);
      #1;

      $display("[TB] zero-wait write to slave 1");
      applyStimulus(32'h4000_1004, 1'b1, 32'hDEAD_BEEF, 4'b0010, 0, 1'b0, 32'h0, 2'b00, 3);

      $display("[TB] read from slave 3 with three wait states");
      applyStimulus(32'h4000_3000, 1'b0, 32'h0, 4'b1000, 3, 1'b0, 32'h1234_5678, 2'b00, 5);

      $display("[TB] back-to-back write slave 0 then read slave 2");
      applyStimulus(32'h4000_0010, 1'b1, 32'hA5A5_0001, 4'b0001, 0, 1'b0, 32'h0, 2'b00, 3);
      applyStimulus(32'h4000_2008, 1'b0, 32'h0, 4'b0100, 0, 1'b0, 32'hCAFE_0002, 2'b00, 2);

      $display("[TB] unmapped reads");
      applyStimulus(32'h5000_0000, 1'b0, 32'h0, 4'b0000, 0, 1'b0, 32'h0, 2'b01, 1);
      applyStimulus(32'h4000_4000, 1'b0, 32'h0, 4'b0000, 0, 1'b0, 32'h0, 2'b01, 1);

      $display("[TB] last word of window 0 with one wait state");
      applyStimulus(32'h4000_0FFC, 1'b0, 32'h0, 4'b0001, 1, 1'b0, 32'h0000_0FFC, 2'b00, 3);

      $display("[TB] slave error then transfer accepted in ERR2");
      applyStimulus(32'h4000_2000, 1'b0, 32'h0, 4'b0100, 0, 1'b1, 32'h0BAD_F00D, 2'b01, 3);
      applyStimulus(32'h4000_100C, 1'b1, 32'h1111_2222, 4'b0010, 0, 1'b0, 32'h0, 2'b00, 3);

      $display("[TB] BUSY and IDLE with hsel high");
      for (int i = 0; i < 12; i++) begin
         @(negedge hclk);
         if (hreadyout) break;
      end
      @(posedge hclk);
      #1;
      hsel = 1'b1; haddr = 32'h4000_1000; hwrite = 1'b1;
      for (int i = 0; i < 4; i++) begin
         htrans = (i < 2) ? 2'b01 : 2'b00;
         @(negedge hclk);
         checkOutput("busy_hreadyout", hreadyout, 1'b1);
         checkOutput("busy_psel", psel, 4'b0000);
         checkOutput("busy_hresp", hresp, 2'b00);
         @(posedge hclk);
         #1;
      end
      hsel = 1'b0; htrans = 2'b00;

      $display("[TB] reset during ACCESS");
      applyStimulus(32'h4000_1000, 1'b0, 32'h0, 4'b0010, 10, 1'b0, 32'h5555_AAAA, 2'b00, 12);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge hclk);
         if ((psel != 4'b0000) && penable) begin
            seen = 1;
            break;
         end
      end
      checkOutput("reach_access", seen, 1'b1);
      hreset = 1'b1;
      #1;
      checkOutput("abort_psel", psel, 4'b0000);
      checkOutput("abort_penable", penable, 1'b0);
      checkOutput("abort_hreadyout", hreadyout, 1'b1);
      checkOutput("abort_hresp", hresp, 2'b00);
      checkOutput("abort_hrdata", hrdata, 32'h0);
      ahb_q.delete();
      apb_q.delete();
      exp_hrdata = 32'h0;
      @(posedge hclk);
      @(negedge hclk);
      @(posedge hclk);
      #2 hreset = 1'b0;
      @(posedge hclk);
      #1;

      $display("[TB] write after reset with two wait states");
      applyStimulus(32'h4000_3FFC, 1'b1, 32'h0000_0007, 4'b1000, 2, 1'b0, 32'h0, 2'b00, 5);

      for (int i = 0; i < 100; i++) begin
         @(negedge hclk);
         if ((ahb_q.size() == 0) && (apb_q.size() == 0) && !pending) break;
      end
      checkOutput("ahb_q_drained", ahb_q.size(), 0);
      checkOutput("apb_q_drained", apb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ahb_apb_bridge_mp.md
Name: ahb_apb_bridge_mp

Overview:
- Parametrised, single-clock AHB-Lite slave to APB3 master bridge, successor to the fixed 3-slave bridge.
- Decodes a configurable number of APB slave windows.
- Supports APB wait states (pready) and maps pslverr and unmapped addresses to a two-cycle AHB ERROR response.
- Sits between the AHB interconnect and the peripheral APB segment; AHB and APB share hclk.

Parameters:
- ADDR_W, 32, address width of haddr/paddr.
- DATA_W, 32, data width of hwdata/hrdata/pwdata/prdata (32 or 64).
- NUM_SLV, 4, number of APB slaves (2..16); IDX_W = $clog2(NUM_SLV).
- SLV_LSB, 12, lowest haddr bit of the slave index; each window is 2^SLV_LSB bytes.
- BASE_ADDR, 32'h4000_0000, APB region base; bits below SLV_LSB+IDX_W must be zero.

Ports:
- hclk  in  1  bridge clock (AHB and APB).
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  AHB slave select.
- haddr  in  ADDR_W  AHB address.
- htrans  in  2  AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- hwrite  in  1  AHB write.
- hsize  in  3  AHB size; registered, forwarded only under the optional feature.
- hwdata  in  DATA_W  AHB write data.
- hreadyin  in  1  AHB bus ready.
- hreadyout  out  1  bridge ready.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  DATA_W  read data.
- psel  out  NUM_SLV  one-hot APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  read data of the selected slave (muxed externally).
- pready  in  1  selected slave ready.
- pslverr  in  1  selected slave error.

Behaviour:
- Reset (async on hreset high): state IDLE, hreadyout=1, hresp=00, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0. All outputs are registered.
- Accept condition: hsel & hreadyin & htrans[1]. When accepted, capture haddr, hwrite, hsize and the decoded index. Acceptance is evaluated only in IDLE, RESP and ERR2.
- IDLE or BUSY with hsel=1: no action, hreadyout stays 1, OKAY.
- Decode: hit when haddr[ADDR_W-1:SLV_LSB+IDX_W] equals the same bits of BASE_ADDR and the index haddr[SLV_LSB+:IDX_W] < NUM_SLV. A miss goes to ERR1 with no APB access.
- States:
  - IDLE/RESP/ERR2 -> on accepted hit: write -> WDATA, read -> SETUP; on accepted miss -> ERR1; otherwise -> IDLE.
  - WDATA: hreadyout=0; pwdata<=hwdata at end of cycle -> SETUP.
  - SETUP: psel[idx]=1, penable=0, paddr/pwrite valid -> ACCESS.
  - ACCESS: psel and penable held; pready=0 stays in ACCESS with all APB outputs stable. On pready=1: psel<=0, penable<=0, hrdata<=prdata (reads only; writes leave hrdata unchanged); pslverr=0 -> RESP, pslverr=1 -> ERR1.
  - RESP: hreadyout=1, hresp=OKAY for one cycle.
  - ERR1: hreadyout=0, hresp=ERROR -> ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. A transfer presented here is accepted normally; the master may instead cancel it by driving IDLE.
- hreadyout is 0 in WDATA, SETUP, ACCESS and ERR1, and 1 otherwise.
- Zero-wait latency: write holds hreadyout low 3 cycles; read holds it low 2 cycles. Each pready=0 cycle adds 1.
- Back-to-back transfers: the address accepted in the RESP cycle produces SETUP (read) or WDATA (write) on the next cycle; no idle bubble on APB beyond the mandatory one.
- Reset mid-transfer aborts immediately to reset values; the APB slave sees psel drop.

Optional Feature:
- Macro AHB_APB_PSTRB_EN.
- Defined: adds output pstrb (DATA_W/8), an APB4 byte strobe derived from the registered hsize and haddr low bits (e.g. byte write at offset 2 gives 4'b0100). pstrb is all-zero on reads and reset 0.
- Undefined: port absent; writes are full-width only and hsize is ignored.

Decomposition:
- Package ahb_apb_pkg: htrans_e, hresp_e, bridge state_e enum, OKAY/ERROR constants, default BASE_ADDR.
- Sub-module ahb_apb_addr_decode (combinational): haddr -> hit, index, one-hot select. Parametrised by ADDR_W, NUM_SLV, SLV_LSB, BASE_ADDR.

Test Plan:
- Write 0x4000_1004 data 0xDEADBEEF, pready=1 -> psel=0010, paddr=0x4000_1004, pwdata=0xDEADBEEF; hreadyout low 3 cycles; OKAY.
- Read 0x4000_3000, slave holds pready=0 for 3 cycles, prdata=0x1234_5678 -> ACCESS lasts 4 cycles; hrdata=0x1234_5678; hreadyout low 5 cycles.
- Write to slave 0 then back-to-back read from slave 2 -> second SETUP follows the RESP cycle; no missed or duplicated psel.
- Read 0x5000_0000 (miss) -> no psel; hresp=01 for 2 cycles with hreadyout 0 then 1.
- Read 0x4000_2000 with pslverr=1 -> ERROR two-cycle response; hrdata updated; next transfer accepted in ERR2.
- hreset pulse during ACCESS -> psel/penable drop same cycle; hreadyout=1.
